nios_oc_mem_arbiter: RTL and testbench

//  Shares the single-port 8192x32 on-chip CPU memory between two Avalon-MM requesters:

---
 rtl/nios_oc_mem_arb_pkg.sv | 18 +
 rtl/oc_mem_rr_arb2.sv | 21 ++
 rtl/nios_oc_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_nios_oc_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_oc_mem_arb_pkg.sv
// Shared definitions for the on-chip CPU memory arbiter: default widths,
// requester port indices and the freeze-sequencing state type.
package nios_oc_mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DATA_W_DEF = 32;

    // Requester indices; last_grant holds one of these
    localparam logic P_CPU = 1'b0;
    localparam logic P_DMA = 1'b1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/oc_mem_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req[1:0]    in   request per port
//   last_grant  in   port granted most recently
//   gnt[1:0]    out  one-hot grant (or zero when nobody requests)
module oc_mem_rr_arb2
    import nios_oc_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // A lone requester wins outright; under contention the other port wins
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant == P_DMA) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/nios_oc_mem_arbiter.sv
// Shares the single-port on-chip CPU memory between the Nios data master
// (port 0) and the PCIe/DMA bridge (port 1) with round-robin arbitration,
// one command per cycle, read latency 1. Sequences the RAM clock enable
// around reset_req: drain outstanding reads, then freeze (reset_ack high).
//
// Optional build macro OC_MEM_ARB_WR_PROTECT_EN: port 1 writes below
// PROT_WORDS are accepted but dropped and set the sticky prot_err flag.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   reset_req / reset_ack        freeze request / frozen indication
//   pN_* (N = 0,1)               Avalon-MM slave side per requester
//   mem_*                        single-port RAM side
//   prot_err / prot_clr          sticky protection flag and its clear
module nios_oc_mem_arbiter
    import nios_oc_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned PROT_WORDS = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reset_req,
    output logic                  reset_ack,

    input  logic [ADDR_W-1:0]     p0_address,
    input  logic [DATA_W/8-1:0]   p0_byteenable,
    input  logic                  p0_read,
    input  logic                  p0_write,
    input  logic [DATA_W-1:0]     p0_writedata,
    output logic                  p0_waitrequest,
    output logic [DATA_W-1:0]     p0_readdata,
    output logic                  p0_readdatavalid,

    input  logic [ADDR_W-1:0]     p1_address,
    input  logic [DATA_W/8-1:0]   p1_byteenable,
    input  logic                  p1_read,
    input  logic                  p1_write,
    input  logic [DATA_W-1:0]     p1_writedata,
    output logic                  p1_waitrequest,
    output logic [DATA_W-1:0]     p1_readdata,
    output logic                  p1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,

    output logic                  prot_err,
    input  logic                  prot_clr
);

    arb_state_t  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  rd_pend_q, rd_pend_d;
    logic        prot_err_q, prot_err_d;

    logic        arb_en_c;
    logic [1:0]  req_c;
    logic [1:0]  gnt_c;
    logic        sel_c;
    logic        prot_region_c;
    logic        prot_block_c;

    // Arbitration only while running and not being asked to freeze
    assign arb_en_c = (state_q == RUN) && !reset_req;
    assign req_c    = {p1_read | p1_write, p0_read | p0_write} & {2{arb_en_c}};

    oc_mem_rr_arb2 u_rr (
        .req        (req_c),
        .last_grant (last_grant_q),
        .gnt        (gnt_c)
    );

    // Extra MSB so a PROT_WORDS equal to the full depth still compares correctly
    assign prot_region_c = {1'b0, p1_address} < (ADDR_W+1)'(PROT_WORDS);

`ifdef OC_MEM_ARB_WR_PROTECT_EN
    assign prot_block_c = gnt_c[P_DMA] & p1_write & prot_region_c;
`else
    logic unused_prot_cfg;
    assign prot_block_c    = 1'b0;
    assign unused_prot_cfg = prot_clr ^ prot_region_c;
`endif

    assign sel_c = gnt_c[P_DMA];

    // RAM command mux; a blocked write is acknowledged to the port but never reaches the RAM
    always_comb begin
        mem_address    = sel_c ? p1_address    : p0_address;
        mem_byteenable = sel_c ? p1_byteenable : p0_byteenable;
        mem_writedata  = sel_c ? p1_writedata  : p0_writedata;
        mem_chipselect = (|gnt_c) & ~prot_block_c;
        mem_write      = mem_chipselect & (sel_c ? p1_write : p0_write);
    end

    // Next-state: grant history, read-return tracking, freeze sequencing, protection flag
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rd_pend_d    = 2'b00;
        prot_err_d   = prot_err_q;

        if (|gnt_c) begin
            last_grant_d = gnt_c[P_DMA];
        end

        // Write wins when a port raises read and write together
        rd_pend_d[P_CPU] = gnt_c[P_CPU] & p0_read & ~p0_write;
        rd_pend_d[P_DMA] = gnt_c[P_DMA] & p1_read & ~p1_write;

        case (state_q)
            RUN:     if (reset_req)        state_d = DRAIN;
            DRAIN:   if (rd_pend_q == 2'b00) state_d = HOLD;
            HOLD:    if (!reset_req)       state_d = RUN;
            default:                       state_d = RUN;
        endcase

`ifdef OC_MEM_ARB_WR_PROTECT_EN
        // A violation in the clearing cycle keeps the flag set
        if (prot_clr)     prot_err_d = 1'b0;
        if (prot_block_c) prot_err_d = 1'b1;
`else
        prot_err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            last_grant_q <= P_DMA;
            rd_pend_q    <= 2'b00;
            prot_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            prot_err_q   <= prot_err_d;
        end
    end

    assign p0_waitrequest   = ~gnt_c[P_CPU];
    assign p1_waitrequest   = ~gnt_c[P_DMA];
    assign p0_readdata      = mem_readdata;
    assign p1_readdata      = mem_readdata;
    assign p0_readdatavalid = rd_pend_q[P_CPU];
    assign p1_readdatavalid = rd_pend_q[P_DMA];
    assign reset_ack        = (state_q == HOLD);
    assign mem_clken        = (state_q != HOLD);
    assign prot_err         = prot_err_q;

endmodule

// File: tb/tb_nios_oc_mem_arbiter.sv
// Self-checking bench for nios_oc_mem_arbiter: a behavioural RAM sits on the
// mem_* side, a reference model predicts grants, RAM contents and protection
// state, and a monitor matches returned read data against a scoreboard.
// Honours OC_MEM_ARB_WR_PROTECT_EN the same way the design does.
module tb_nios_oc_mem_arbiter;

    localparam int unsigned AW         = 13;
    localparam int unsigned DW         = 32;
    localparam int unsigned DEPTH      = 8192;
    localparam int unsigned PROT_WORDS = 4096;
`ifdef OC_MEM_ARB_WR_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    logic          clk, reset_n, reset_req, reset_ack;
    logic [AW-1:0] p0_address, p1_address;
    logic [3:0]    p0_byteenable, p1_byteenable;
    logic          p0_read, p0_write, p1_read, p1_write;
    logic [DW-1:0] p0_writedata, p1_writedata;
    logic          p0_waitrequest, p1_waitrequest;
    logic [DW-1:0] p0_readdata, p1_readdata;
    logic          p0_readdatavalid, p1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata, mem_readdata;
    logic          prot_err, prot_clr;

    nios_oc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PROT_WORDS(PROT_WORDS)) dut (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .reset_ack(reset_ack),
        .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
        .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
        .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
        .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
        .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
        .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .prot_err(prot_err), .prot_clr(prot_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Environment RAM: single port, registered read, gated by clock enable
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_q;
    assign mem_readdata = ram_q;
    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_chipselect && mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            ram_q <= ram[mem_address];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int  m_phase;   // 0 running, 1 draining, 2 frozen
    bit  m_last;    // port granted most recently
    bit  m_pend;    // a read was granted in the previous cycle
    bit  m_prot;

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    task automatic model_reset();
        m_phase = 0; m_last = 1'b1; m_pend = 1'b0; m_prot = 1'b0;
        q0.delete(); q1.delete();
    endtask

    task automatic idle_inputs();
        p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0; prot_clr = 0;
    endtask

    // One clock: predict and check the combinational response to the inputs
    // already applied, then the registered outputs after the edge.
    task automatic step();
        int win; bit blk, pend_n, prot_n, wr, rd;
        logic [AW-1:0] a; logic [3:0] be; logic [31:0] wd;
        exp_t e;
        #1;
        win = -1;
        if (m_phase == 0 && !reset_req) begin
            if ((p0_read | p0_write) && (p1_read | p1_write)) win = m_last ? 0 : 1;
            else if (p0_read | p0_write)                      win = 0;
            else if (p1_read | p1_write)                      win = 1;
        end
        blk = PROT_ON && win == 1 && p1_write && (int'(p1_address) < int'(PROT_WORDS));
        chk("p0_waitrequest", 32'(p0_waitrequest), 32'(win != 0));
        chk("p1_waitrequest", 32'(p1_waitrequest), 32'(win != 1));
        chk("mem_chipselect", 32'(mem_chipselect), 32'(win >= 0 && !blk));
        pend_n = 0;
        prot_n = m_prot;
        if (PROT_ON && prot_clr) prot_n = 0;
        if (win >= 0) begin
            wr = (win == 0) ? p0_write : p1_write;
            rd = (win == 0) ? p0_read  : p1_read;
            a  = (win == 0) ? p0_address : p1_address;
            be = (win == 0) ? p0_byteenable : p1_byteenable;
            wd = (win == 0) ? p0_writedata : p1_writedata;
            if (!blk) begin
                chk("mem_address", 32'(mem_address), 32'(a));
                chk("mem_write", 32'(mem_write), 32'(wr));
            end
            if (wr) begin
                if (blk) prot_n = 1;
                else begin
                    chk("mem_writedata", mem_writedata, wd);
                    chk("mem_byteenable", 32'(mem_byteenable), 32'(be));
                    ref_mem[a] = merge(ref_mem[a], wd, be);
                end
            end else if (rd) begin
                e.data = ref_mem[a]; e.cyc = cyc; pend_n = 1;
                if (win == 0) q0.push_back(e); else q1.push_back(e);
            end
            m_last = (win == 1);
        end
        case (m_phase)
            0: if (reset_req) m_phase = 1;
            1: if (!m_pend)   m_phase = 2;
            default: if (!reset_req) m_phase = 0;
        endcase
        @(posedge clk);
        #1;
        m_pend = pend_n;
        m_prot = prot_n;
        chk("reset_ack", 32'(reset_ack), 32'(m_phase == 2));
        chk("mem_clken", 32'(mem_clken), 32'(m_phase != 2));
        chk("prot_err",  32'(prot_err),  32'(m_prot));
        @(negedge clk);
    endtask

    // Monitor: every valid strobe must match the oldest expectation for its port,
    // and arrive exactly one cycle after the grant.
    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t e; int n;
        n = (p == 0) ? q0.size() : q1.size();
        if (v) begin
            if (n == 0) chk(p == 0 ? "p0_unexpected_valid" : "p1_unexpected_valid", 32'd1, 32'd0);
            else begin
                if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk(p == 0 ? "p0_readdata" : "p1_readdata", d, e.data);
                chk(p == 0 ? "p0_latency" : "p1_latency", 32'(cyc - e.cyc), 32'd1);
            end
        end else if (n != 0) begin
            e = (p == 0) ? q0[0] : q1[0];
            if (e.cyc + 1 <= cyc) begin
                chk(p == 0 ? "p0_missing_valid" : "p1_missing_valid", 32'd0, 32'd1);
                if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, p0_readdatavalid, p0_readdata);
        mon(1, p1_readdatavalid, p1_readdata);
    end

    function automatic logic [AW-1:0] rnd_addr();
        case ($urandom_range(0, 3))
            0:       return AW'($urandom_range(0, 7));
            1:       return AW'($urandom_range(PROT_WORDS - 3, PROT_WORDS + 3));
            2:       return AW'($urandom_range(DEPTH - 7, DEPTH - 1));
            default: return AW'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    task automatic rnd_port(input int p);
        int k = $urandom_range(0, 3);   // idle, read, write, read+write
        logic [AW-1:0] a = rnd_addr();
        logic [3:0] be = 4'($urandom_range(1, 15));
        logic [31:0] d = $urandom;
        if (p == 0) begin
            p0_read = (k == 1 || k == 3); p0_write = (k >= 2);
            p0_address = a; p0_byteenable = be; p0_writedata = d;
        end else begin
            p1_read = (k == 1 || k == 3); p1_write = (k >= 2);
            p1_address = a; p1_byteenable = be; p1_writedata = d;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        ram_q = '0;
        reset_n = 0; reset_req = 0;
        p0_address = '0; p1_address = '0; p0_byteenable = 4'hF; p1_byteenable = 4'hF;
        p0_writedata = '0; p1_writedata = '0;
        idle_inputs();
        model_reset();
        #12;
        chk("rst_p0_wait", 32'(p0_waitrequest), 32'd1);
        chk("rst_p1_wait", 32'(p1_waitrequest), 32'd1);
        chk("rst_p0_rdv", 32'(p0_readdatavalid), 32'd0);
        chk("rst_p1_rdv", 32'(p1_readdatavalid), 32'd0);
        chk("rst_ack", 32'(reset_ack), 32'd0);
        chk("rst_prot_err", 32'(prot_err), 32'd0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // Lone read from port 0
        p0_read = 1; p0_address = 13'h0010; step();
        idle_inputs(); step();

        // Continuous contention: strict alternation
        for (int i = 0; i < 6; i++) begin
            p0_read = 1; p1_read = 1;
            p0_address = AW'(32 + i); p1_address = AW'(64 + i);
            step();
        end
        idle_inputs(); step();

        // Partial write from port 1 then read-back from port 0
        p1_write = 1; p1_address = 13'h1FFF; p1_writedata = 32'hDEADBEEF; p1_byteenable = 4'b0011;
        step();
        idle_inputs(); p0_read = 1; p0_address = 13'h1FFF; step();
        idle_inputs(); step();
        chk("merge_1fff", ram[13'h1FFF], {init_word(13'h1FFF) & 32'hFFFF0000} | 32'h0000BEEF);

        // Freeze while a read is returning; requests during freeze must stall
        p0_read = 1; p0_address = 13'h0005; step();
        idle_inputs(); reset_req = 1; step();
        p1_read = 1; p1_address = 13'h0006;
        repeat (3) step();
        chk("hold_ack", 32'(reset_ack), 32'd1);
        reset_req = 0; step();
        step();
        idle_inputs(); step();

        // Port 1 write into the protected region, then a legitimate write there
        p1_write = 1; p1_address = 13'h0100; p1_writedata = 32'h12345678; p1_byteenable = 4'hF;
        step();
        idle_inputs();
        p0_write = 1; p0_address = 13'h0100; p0_writedata = 32'hCAFEF00D; p0_byteenable = 4'hF;
        step();
        idle_inputs(); prot_clr = 1; step();
        idle_inputs(); p0_read = 1; p0_address = 13'h0100; step();
        idle_inputs(); step();

        // Async reset with a read return pending: the strobe is dropped
        p0_read = 1; p0_address = 13'h0042;
        #1 chk("t6_grant", 32'(p0_waitrequest), 32'd0);
        @(posedge clk); #1;
        reset_n = 0; idle_inputs(); model_reset();
        #1 chk("t6_rdv_dropped", 32'(p0_readdatavalid), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        repeat (3) step();
        p0_read = 1; p1_read = 1; p0_address = 13'h0003; p1_address = 13'h0004;
        step();
        idle_inputs(); step();

        // Randomised traffic with freeze requests and flag clears
        for (int i = 0; i < 800; i++) begin
            rnd_port(0);
            rnd_port(1);
            if (reset_req) reset_req = ($urandom_range(0, 9) >= 3);
            else           reset_req = ($urandom_range(0, 29) == 0);
            prot_clr = ($urandom_range(0, 7) == 0);
            step();
        end

        reset_req = 0; idle_inputs();
        repeat (6) step();
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
